// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window generator and the PE it feeds.
package conv_pkg;

  localparam int PIC_BITS    = 2;
  localparam int KERNEL_SIZE = 5;
  localparam int WIN_N       = KERNEL_SIZE * KERNEL_SIZE;

  typedef logic [PIC_BITS-1:0] pixel_t;
  typedef pixel_t win_t [WIN_N-1:0];

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of delay: a circular buffer that returns the pixel written
// DEPTH accepted pixels ago and overwrites it with the new one.
module line_buffer
  import conv_pkg::*;
#(
  parameter int WIDTH = PIC_BITS,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;

  // Read-before-write: the slot under the pointer holds the oldest pixel.
  assign dout = r_mem[r_ptr];

  // Circular pointer, advanced once per accepted pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (en) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // Storage is not reset; stale contents are masked by the row gate upstream.
  always_ff @(posedge clk) begin
    if (en) begin
      r_mem[r_ptr] <= din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming K x K valid-mode window generator for a raster-order image.
// K-1 chained line buffers supply the vertical column, a K x K shift register
// holds the sliding window, and a window is registered out for every pixel
// at row >= K-1 and column >= K-1.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int pic_bits    = PIC_BITS,
  parameter int kernel_size = KERNEL_SIZE,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_valid,
  input  logic [pic_bits-1:0]        pix_in,
  output logic                       win_valid,
  output logic [pic_bits-1:0]        win [kernel_size*kernel_size-1:0],
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       frame_done
);

  localparam int K  = kernel_size;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  localparam logic [RW-1:0] ROW_GATE = RW'(K - 1);
  localparam logic [CW-1:0] COL_GATE = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic                w_en;
  logic                w_emit;
  logic                w_last_pix;
  logic [pic_bits-1:0] w_lb_out [K-1];
  logic [pic_bits-1:0] w_col    [K];
  logic [pic_bits-1:0] r_sr     [K][K];
  logic [pic_bits-1:0] w_next   [K][K];

  // A pixel sampled while reset is low is dropped everywhere.
  assign w_en = pix_valid & rst_n;

  // Line buffer k delays the stream by k+1 rows.
  for (genvar k = 0; k < K - 1; k++) begin : g_lb
    if (k == 0) begin : g_first
      line_buffer #(.WIDTH(pic_bits), .DEPTH(IMG_W)) u_lb (
        .clk(clk), .rst_n(rst_n), .en(w_en), .din(pix_in), .dout(w_lb_out[k])
      );
    end else begin : g_chain
      line_buffer #(.WIDTH(pic_bits), .DEPTH(IMG_W)) u_lb (
        .clk(clk), .rst_n(rst_n), .en(w_en), .din(w_lb_out[k-1]), .dout(w_lb_out[k])
      );
    end
    assign w_col[K-2-k] = w_lb_out[k];
  end
  assign w_col[K-1] = pix_in;

  assign w_emit     = pix_valid && (r_row >= ROW_GATE) && (r_col >= COL_GATE);
  assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // Window after this pixel: shift every row one column left, load the new column.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        w_next[i][j] = r_sr[i][j+1];
      end
      w_next[i][K-1] = w_col[i];
    end
  end

  // Raster position of the next accepted pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (pix_valid) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Sliding window storage; contents are only exposed through the gated output.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_sr <= w_next;
    end
  end

  // Registered window output; win and position hold between emissions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      for (int n = 0; n < K * K; n++) begin
        win[n] <= '0;
      end
    end else begin
      win_valid  <= w_emit;
      frame_done <= w_emit && w_last_pix;
      if (w_emit) begin
        win_row <= r_row - ROW_GATE;
        win_col <= r_col - COL_GATE;
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            win[i*K+j] <= w_next[i][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: an image-array reference model predicts every
// output cycle by cycle; scenario checks pin the model with literal values.
module tb_conv_window_gen;

  localparam int K  = 5;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = K * K;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_valid;
  logic [1:0] pix_in;
  logic       win_valid;
  logic [1:0] win [N-1:0];
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic       frame_done;

  conv_window_gen #(.pic_bits(2), .kernel_size(K), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_in(pix_in),
    .win_valid(win_valid), .win(win), .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the image as written so far plus the raster position.
  int img [H][W];
  int m_r = 0, m_c = 0;
  int exp_valid = 0, exp_done = 0, exp_row = 0, exp_col = 0;
  int exp_win [N];

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_r = 0; m_c = 0;
      exp_valid = 0; exp_done = 0; exp_row = 0; exp_col = 0;
      for (int n = 0; n < N; n++) exp_win[n] = 0;
    end else begin
      exp_valid = 0;
      exp_done  = 0;
      if (pix_valid) begin
        img[m_r][m_c] = int'(pix_in);
        if (m_r >= K - 1 && m_c >= K - 1) begin
          exp_valid = 1;
          exp_row   = m_r - K + 1;
          exp_col   = m_c - K + 1;
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              exp_win[i*K+j] = img[exp_row+i][exp_col+j];
          exp_done = (m_r == H - 1 && m_c == W - 1) ? 1 : 0;
        end
        if (m_c == W - 1) begin
          m_c = 0;
          m_r = (m_r == H - 1) ? 0 : m_r + 1;
        end else begin
          m_c++;
        end
      end
    end
  end

  // Per-scenario statistics gathered from DUT output.
  bit cmp_en = 0;
  int n_win = 0, n_done = 0;
  int first_row, first_col, last_row, last_col;
  int first_win [N];
  int last_win  [N];

  always @(negedge clk) begin
    if (cmp_en) begin
      int bad;
      chk("win_valid", int'(win_valid), exp_valid);
      chk("frame_done", int'(frame_done), exp_done);
      chk("win_row", int'(win_row), exp_row);
      chk("win_col", int'(win_col), exp_col);
      bad = -1;
      for (int n = N - 1; n >= 0; n--)
        if (int'(win[n]) != exp_win[n]) bad = n;
      if (bad >= 0) chk($sformatf("win[%0d]", bad), int'(win[bad]), exp_win[bad]);
      else          chk("win", 0, 0 + (bad + 1));
      if (win_valid === 1'b1) begin
        if (n_win == 0) begin
          first_row = int'(win_row); first_col = int'(win_col);
          for (int n = 0; n < N; n++) first_win[n] = int'(win[n]);
        end
        last_row = int'(win_row); last_col = int'(win_col);
        for (int n = 0; n < N; n++) last_win[n] = int'(win[n]);
        n_win++;
      end
      if (frame_done === 1'b1) n_done++;
    end
  end

  task automatic clear_stats();
    n_win = 0; n_done = 0;
    first_row = -1; first_col = -1; last_row = -1; last_col = -1;
    for (int n = 0; n < N; n++) begin first_win[n] = -1; last_win[n] = -1; end
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_in    = 2'($urandom);
    repeat (n) @(negedge clk);
  endtask

  // smode: 0 continuous, 1 stall before every pixel, 2 random stalls
  task automatic drive_pix(input logic [1:0] v, input int smode);
    if (smode == 1 || (smode == 2 && $urandom_range(0, 2) == 0)) begin
      pix_valid = 1'b0;
      pix_in    = 2'($urandom);
      @(negedge clk);
    end
    pix_valid = 1'b1;
    pix_in    = v;
    @(negedge clk);
  endtask

  // mode: 0 constant val, 1 (r+c)%4, 2 random
  task automatic send_frame(input int mode, input int val, input int smode);
    logic [1:0] v;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0:       v = 2'(val);
          1:       v = 2'((r + c) % 4);
          default: v = 2'($urandom);
        endcase
        drive_pix(v, smode);
      end
    end
  endtask

  function automatic int win_sum(input int a [N]);
    int s = 0;
    for (int n = 0; n < N; n++) s += a[n];
    return s;
  endfunction

  initial begin
    rst_n = 1'b0; pix_valid = 1'b0; pix_in = 2'd0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_win_row", int'(win_row), 0);
    chk("rst_win_col", int'(win_col), 0);
    chk("rst_win0", int'(win[0]), 0);
    rst_n = 1'b1;
    idle(2);

    // All-ones image, continuous input
    clear_stats();
    send_frame(0, 1, 0);
    idle(3);
    chk("ones_nwin", n_win, 8);
    chk("ones_ndone", n_done, 1);
    chk("ones_first_sum", win_sum(first_win), 25);
    chk("ones_last_sum", win_sum(last_win), 25);

    // Diagonal pattern, continuous input
    clear_stats();
    send_frame(1, 0, 0);
    idle(3);
    chk("diag_nwin", n_win, 8);
    chk("diag_first_row", first_row, 0);
    chk("diag_first_col", first_col, 0);
    chk("diag_first_w0", first_win[0], 0);
    chk("diag_first_w1", first_win[1], 1);
    chk("diag_first_w24", first_win[24], 0);
    chk("diag_last_row", last_row, 1);
    chk("diag_last_col", last_col, 3);
    chk("diag_last_w0", last_win[0], 0);
    chk("diag_ndone", n_done, 1);

    // Same pattern, stall every other cycle
    clear_stats();
    send_frame(1, 0, 1);
    idle(3);
    chk("stall_nwin", n_win, 8);
    chk("stall_first_w1", first_win[1], 1);
    chk("stall_last_row", last_row, 1);
    chk("stall_last_col", last_col, 3);
    chk("stall_ndone", n_done, 1);

    // Abort after 20 pixels; reset coincides with a valid pixel
    for (int n = 0; n < 20; n++) drive_pix(2'($urandom), 0);
    rst_n = 1'b0; pix_valid = 1'b1; pix_in = 2'd3;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    send_frame(0, 2, 0);
    idle(3);
    chk("abort_nwin", n_win, 8);
    chk("abort_first_row", first_row, 0);
    chk("abort_first_sum", win_sum(first_win), 50);
    chk("abort_last_sum", win_sum(last_win), 50);
    chk("abort_ndone", n_done, 1);

    // Back-to-back frames: all-1 then all-3
    clear_stats();
    send_frame(0, 1, 0);
    send_frame(0, 3, 0);
    idle(3);
    chk("b2b_nwin", n_win, 16);
    chk("b2b_ndone", n_done, 2);
    chk("b2b_first_sum", win_sum(first_win), 25);
    chk("b2b_last_sum", win_sum(last_win), 75);

    // Random images with random stalls
    clear_stats();
    for (int f = 0; f < 3; f++) send_frame(2, 0, 2);
    idle(3);
    chk("rand_nwin", n_win, 24);
    chk("rand_ndone", n_done, 3);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming sliding-window generator that feeds the convolution processing element. It accepts a raster-order pixel stream of one `IMG_W`×`IMG_H` single-channel image and emits every valid-mode (no padding) `kernel_size`×`kernel_size` window. It drives the PE's `in_valid`/`pic` inputs directly, in the PE's array layout. It buffers `kernel_size-1` image rows internally.

## Interface
- `pic_bits`, 2, pixel width (matches PE)
- `kernel_size`, 5, window edge length K
- `IMG_W`, 8, image width in pixels, ≥ K
- `IMG_H`, 6, image height in pixels, ≥ K
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `pix_valid`  in  1  `pix_in` carries the next raster pixel this cycle
- `pix_in`  in  `pic_bits`  pixel value
- `win_valid`  out  1  window on `win` is valid for one cycle; connects to PE `in_valid`
- `win`  out  `pic_bits` × K*K (unpacked `[K*K-1:0]`)  window; connects to PE `pic`
- `win_row`  out  `$clog2(IMG_H)`  top row of the emitted window
- `win_col`  out  `$clog2(IMG_W)`  left column of the emitted window
- `frame_done`  out  1  one-cycle pulse coincident with the last window of a frame

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) give the position of the next accepted pixel. They advance only when `pix_valid` is high.
  - `col` wraps to 0 at IMG_W-1 and increments `row`.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0 and the next pixel starts a new frame.
- K-1 line buffers, each IMG_W deep, delay the stream by 1..K-1 rows. A K×K shift register shifts one column left per accepted pixel and loads the K vertically aligned pixels.
- A window is emitted for an accepted pixel at (r, c) iff r ≥ K-1 and c ≥ K-1.
  - Top-left corner of that window = (r-K+1, c-K+1).
  - `win[i*K+j]` = pixel(top+i, left+j), so index 0 is top-left and index K*K-1 is bottom-right (the current pixel).
- Windows never straddle a row wrap. Columns < K-1 of each row only fill the shift register.
- Windows per frame = (IMG_W-K+1)·(IMG_H-K+1).
- `pix_valid` low is a stall: no state change, no window.
- No backpressure. The PE must accept one window per cycle.
- Reset values: `win_valid`=0, `frame_done`=0, `win` all 0, `win_row`=0, `win_col`=0, counters 0.
  - Line-buffer contents are not reset. They are never exposed, because emission is gated by `row` ≥ K-1.
- Reset mid-frame: the in-flight frame is abandoned. The first `pix_valid` after `rst_n` rises is pixel (0,0).

## Timing
- Latency: `win_valid`, `win`, `win_row`, `win_col` and `frame_done` are registered. They assert the cycle after the triggering pixel is sampled.
- `win_valid` is a single-cycle pulse per window. `win` holds its last value while `win_valid` is low.
- Back-to-back `pix_valid` on a window-producing row gives back-to-back `win_valid`.
- `frame_done` asserts together with `win_valid` for window (IMG_H-K, IMG_W-K).
- Frame boundary: the pixel accepted in the cycle after the last pixel belongs to (0,0) of the next frame.
  - That pixel produces no window.
  - The line buffers hold prior-frame data, which is masked by the row gate.
- `rst_n` low in a cycle with `pix_valid` high: reset wins and the pixel is dropped.

## Structure
- Shared package `conv_pkg`:
  - `pixel_t` (`logic [pic_bits-1:0]`)
  - window array typedef
  - `KERNEL_SIZE` and `PIC_BITS` constants, shared with the PE
- Sub-module `line_buffer`:
  - one IMG_W-deep, `pic_bits`-wide delay line with an enable
  - circular pointer; read-before-write on the same address
  - instantiated K-1 times, chained

## Test plan
- All-ones image, continuous `pix_valid`, defaults (8×6, K=5) → exactly 8 `win_valid` pulses, every `win` element = 1. With PE weights = 1, each PE result = 25.
- Image p(r,c)=(r+c)%4 → first window at (0,0) one cycle after pixel (4,4) is sampled, with `win[0]`=0, `win[1]`=1, `win[24]`=0. Last window at (1,3) with `win[0]`=0 and `frame_done`=1 on that cycle only.
- Same image with `pix_valid` deasserted every other cycle → identical window sequence and contents, 8 windows, no window in any stall cycle.
- Reset asserted after 20 pixels of a frame, then a full frame of all-2 pixels → 8 windows of all-2, no window before row 4, no stale data from the aborted frame.
- Two frames back-to-back with no gap (frame 1 all-1, frame 2 all-3) → 16 windows: first 8 all-1, next 8 all-3, `frame_done` pulses twice, no window on pixel (0,0) of frame 2.
